// File: rtl/idli_slice_alu.sv
// Slice-serial ALU with a full-word comparator, LSB slice first.
// One result slice per accepted beat, registered, one cycle latency.
package idli_pkg;
    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_AND,
        ALU_OR,
        ALU_XOR
    } alu_op_t;

    typedef enum logic [2:0] {
        CMP_OP_EQ,
        CMP_OP_NE,
        CMP_OP_LT,
        CMP_OP_LTU,
        CMP_OP_GE,
        CMP_OP_GEU,
        CMP_OP_ANY
    } cmp_op_t;
endpackage

module idli_slice_alu
    import idli_pkg::*;
#(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_vld,
    input  logic               i_flush,
    input  alu_op_t            i_op,
    input  logic               i_sub,
    input  cmp_op_t            i_cmp_op,
    input  logic [SLICE_W-1:0] i_lhs,
    input  logic [SLICE_W-1:0] i_rhs,
    output logic               o_vld,
    output logic [SLICE_W-1:0] o_res,
    output logic               o_last,
    output logic               o_cmp,
    output logic               o_cout
);

    localparam int CTR_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(NUM_SLICES - 1);

    logic [CTR_W-1:0]   ctr;
    alu_op_t            op_q;
    logic               sub_q;
    cmp_op_t            cmp_q;
    logic               carry_q;
    logic               ccarry_q;
    logic               z_q;

    logic               first;
    logic               last;
    logic               beat;
    alu_op_t            op;
    logic               sub;
    cmp_op_t            cmp_op;
    logic               cin;
    logic               ccin;
    logic [SLICE_W-1:0] rhs_eff;
    logic [SLICE_W:0]   sum;
    logic [SLICE_W:0]   diff;
    logic [SLICE_W-1:0] res;
    logic               c_msb;
    logic               ovf;
    logic               lt;
    logic               ltu;
    logic               z_nxt;
    logic               pred;

    always_comb begin
        first   = (ctr == '0);
        last    = (ctr == LAST_IDX);
        beat    = i_vld & ~i_flush;
        op      = first ? i_op     : op_q;
        sub     = first ? i_sub    : sub_q;
        cmp_op  = first ? i_cmp_op : cmp_q;
        cin     = first ? i_sub    : carry_q;
        ccin    = first ? 1'b1     : ccarry_q;
        rhs_eff = sub ? ~i_rhs : i_rhs;
        sum     = {1'b0, i_lhs} + {1'b0, rhs_eff}
                + {{SLICE_W{1'b0}}, cin};
        diff    = {1'b0, i_lhs} + {1'b0, ~i_rhs}
                + {{SLICE_W{1'b0}}, ccin};

        res = '0;
        unique case (op)
            ALU_ADD: res = sum[SLICE_W-1:0];
            ALU_AND: res = i_lhs & i_rhs;
            ALU_OR:  res = i_lhs | i_rhs;
            ALU_XOR: res = i_lhs ^ i_rhs;
            default: res = '0;
        endcase

        // Recover the carry into the MSB from the sum bit and its operands.
        c_msb = diff[SLICE_W-1] ^ i_lhs[SLICE_W-1] ^ ~i_rhs[SLICE_W-1];
        ovf   = c_msb ^ diff[SLICE_W];
        lt    = diff[SLICE_W-1] ^ ovf;
        ltu   = ~diff[SLICE_W];
        z_nxt = (first | z_q) & (diff[SLICE_W-1:0] == '0);

        pred = 1'b0;
        case (cmp_op)
            CMP_OP_EQ:  pred = z_nxt;
            CMP_OP_NE:  pred = ~z_nxt;
            CMP_OP_LT:  pred = lt;
            CMP_OP_LTU: pred = ltu;
            CMP_OP_GE:  pred = ~lt;
            CMP_OP_GEU: pred = ~ltu;
            CMP_OP_ANY: pred = 1'b1;
            default:    pred = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctr      <= '0;
            op_q     <= ALU_ADD;
            sub_q    <= 1'b0;
            cmp_q    <= CMP_OP_EQ;
            carry_q  <= 1'b0;
            ccarry_q <= 1'b0;
            z_q      <= 1'b1;
            o_vld    <= 1'b0;
            o_res    <= '0;
            o_last   <= 1'b0;
            o_cmp    <= 1'b0;
            o_cout   <= 1'b0;
        end else begin
            o_vld  <= beat;
            o_res  <= beat ? res : '0;
            o_last <= beat & last;
            o_cmp  <= beat & last & pred;
            o_cout <= beat & last & (op == ALU_ADD) & sum[SLICE_W];
            if (i_flush) begin
                ctr      <= '0;
                carry_q  <= 1'b0;
                ccarry_q <= 1'b0;
            end else if (i_vld) begin
                ctr      <= last ? '0 : ctr + 1'b1;
                carry_q  <= sum[SLICE_W];
                ccarry_q <= diff[SLICE_W];
                z_q      <= z_nxt;
                if (first) begin
                    op_q  <= i_op;
                    sub_q <= i_sub;
                    cmp_q <= i_cmp_op;
                end
            end
        end
    end

endmodule
